pnr_trigger_sequencer: RTL and testbench
========================================

// Module: pnr_trigger_sequencer
// PURPOSE
//  Sequences the photon-number-resolving comparator bank from one external trigger.
//  Per accepted trigger it issues a 1-cycle clear pulse (PNR trigger input), then after a
//  programmable delay a sampling gate of programmable width (PNR delayed_trigger input).
//  A holdoff follows. Accepted/missed triggers are counted for the register bank.
//  Sits between the trigger input pin/sync logic and PNR_main, in the ADC_CLK domain.
// PARAMETERS
//  DLY_W  16  width of delay_cycles_i / window_cycles_i / holdoff_cycles_i
//  CNT_W  32  width of trig_count_o / missed_count_o
// PORTS
//  ADC_CLK           in   1      sole clock (125 MHz ADC clock)
//  rst_i             in   1      asynchronous, active-high reset
//  ext_trig_i        in   1      raw external trigger, asynchronous to ADC_CLK
//  en_i              in   1      sequencer enable; 0 aborts any sequence
//  single_i          in   1      1 = single-shot (re-arm via arm_i), 0 = continuous
//  arm_i             in   1      1-cycle arm pulse (single-shot mode only)
//  delay_cycles_i    in   DLY_W  cycles from clear pulse to gate start (0 treated as 1)
//  window_cycles_i   in   DLY_W  gate width in cycles (0 = no gate)
//  holdoff_cycles_i  in   DLY_W  dead time after gate end
//  cnt_clr_i         in   1      synchronous clear of both counters
//  pnr_clr_o         out  1      1-cycle clear pulse to PNR trigger input
//  pnr_gate_o        out  1      sampling gate to PNR delayed_trigger input
//  busy_o            out  1      high in any state other than IDLE
//  armed_o           out  1      sequencer will accept the next trigger edge
//  trig_count_o      out  CNT_W  accepted triggers
//  missed_count_o    out  CNT_W  rejected edges (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, armed flag 0, counters 0.
//  - ext_trig_i: 2-FF synchroniser + rising-edge detect -> 1-cycle edge flag (3-cycle latency).
//  - armed = en_i & (~single_i | arm flag). arm flag set by arm_i, cleared on sequence
//    completion in single mode; arm_i same cycle as completion -> flag stays set.
//  - FSM IDLE/DELAY/WINDOW/HOLDOFF; one down-counter, width DLY_W.
//  - IDLE: edge & armed -> latch delay/window/holdoff into shadow regs, pnr_clr_o=1 next
//    cycle, trig_count++ (saturating), -> DELAY. Config changes mid-sequence have no effect.
//  - DELAY: gate rises exactly max(D,1) cycles after the clear-pulse cycle -> WINDOW,
//    or -> HOLDOFF if W=0.
//  - WINDOW: pnr_gate_o high exactly W consecutive cycles -> HOLDOFF.
//  - HOLDOFF: H cycles (H=0 -> return to IDLE the next cycle) -> IDLE.
//  - pnr_gate_o and pnr_clr_o are registered and never high in the same cycle.
//  - en_i=0 in any state -> IDLE next cycle, gate/clear deassert next cycle,
//    arm flag cleared, counters held.
//  - Edge in IDLE while not armed: ignored, not counted.
//  - Counters saturate at all-ones. cnt_clr_i wins over a simultaneous increment.
// CONFIGURATION
//  - PNR_SEQ_MISSED_CNT_EN defined: missed_count_o increments (saturating) on every edge
//    detected while in DELAY, WINDOW or HOLDOFF.
//  - PNR_SEQ_MISSED_CNT_EN undefined: missed-edge counter logic is not built;
//    missed_count_o tied to 0.
// TESTING
//  1 en=1,single=0,D=4,W=10,H=20; one edge -> clr 1 cycle, gate high 10 cycles starting
//    4 cycles after clr; trig_count=1.
//  2 same config; second edge 8 cycles after first -> no new clr; trig_count=1;
//    missed_count=1 (0 if macro undefined).
//  3 single=1, no arm_i; edge -> no clr, count 0. Pulse arm_i, then two edges spaced
//    100 cycles -> exactly one sequence; armed_o=0 afterwards.
//  4 D=0,W=0,H=0 -> clr pulse, no gate, gate-start timing as D=1, back to IDLE;
//    next edge accepted.
//  5 en_i dropped at gate cycle 3 of W=10 -> gate low next cycle, busy_o=0.
//    Assert rst_i mid-WINDOW -> outputs 0 asynchronously.
//  6 Preset trig_count near all-ones via repeated triggers (CNT_W=4 build) -> saturates
//    at 15; cnt_clr_i with a simultaneous accept -> 0.

Source files
------------

// File: rtl/pnr_trigger_sequencer.sv
// Trigger sequencer for the PNR comparator bank: clear pulse, delayed sampling gate, holdoff.
// Optional missed-edge counter is built when PNR_SEQ_MISSED_CNT_EN is defined.
module pnr_trigger_sequencer #(
  parameter int unsigned DLY_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             ADC_CLK,
  input  logic             rst_i,
  input  logic             ext_trig_i,
  input  logic             en_i,
  input  logic             single_i,
  input  logic             arm_i,
  input  logic [DLY_W-1:0] delay_cycles_i,
  input  logic [DLY_W-1:0] window_cycles_i,
  input  logic [DLY_W-1:0] holdoff_cycles_i,
  input  logic             cnt_clr_i,
  output logic             pnr_clr_o,
  output logic             pnr_gate_o,
  output logic             busy_o,
  output logic             armed_o,
  output logic [CNT_W-1:0] trig_count_o,
  output logic [CNT_W-1:0] missed_count_o
);

  typedef enum logic [1:0] {StIdle, StDelay, StWindow, StHoldoff} state_e;

  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] win_q, win_d;
  logic [DLY_W-1:0] hold_q, hold_d;
  logic [DLY_W-1:0] hold_ld;
  logic [2:0]       sync_q;
  logic             edge_q;
  logic             arm_q, arm_d;
  logic             clr_q, clr_d;
  logic             gate_q, gate_d;
  logic             armed;
  logic             accept;
  logic             done;
  logic [CNT_W-1:0] trig_q;

  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is the edge-detect history.
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], ext_trig_i};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign armed   = en_i & (~single_i | arm_q);
  assign accept  = (state_q == StIdle) & edge_q & armed;
  assign hold_ld = (hold_q == '0) ? '0 : hold_q - DLY_W'(1);

  // State register
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      win_q   <= '0;
      hold_q  <= '0;
      arm_q   <= 1'b0;
      clr_q   <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      arm_q   <= arm_d;
      clr_q   <= clr_d;
      gate_q  <= gate_d;
    end
  end

  // Next state; the counter is loaded with (cycles - 1) so zero means "last cycle here".
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    hold_d  = hold_q;
    done    = 1'b0;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StDelay;
            cnt_d   = (delay_cycles_i == '0) ? '0 : delay_cycles_i - DLY_W'(1);
            win_d   = window_cycles_i;
            hold_d  = holdoff_cycles_i;
          end
        end
        StDelay: begin
          if (cnt_q == '0) begin
            if (win_q == '0) begin
              state_d = StHoldoff;
              cnt_d   = hold_ld;
            end else begin
              state_d = StWindow;
              cnt_d   = win_q - DLY_W'(1);
            end
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        StWindow: begin
          if (cnt_q == '0) begin
            state_d = StHoldoff;
            cnt_d   = hold_ld;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        StHoldoff: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs (registered next cycle)
  always_comb begin
    clr_d  = accept;
    gate_d = (state_d == StWindow);
    arm_d  = arm_q;
    if (!en_i) begin
      arm_d = 1'b0;
    end else if (arm_i) begin
      arm_d = 1'b1;
    end else if (done && single_i) begin
      arm_d = 1'b0;
    end
  end

  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      trig_q <= '0;
    end else if (cnt_clr_i) begin
      trig_q <= '0;
    end else if (accept && (trig_q != '1)) begin
      trig_q <= trig_q + CNT_W'(1);
    end
  end

`ifdef PNR_SEQ_MISSED_CNT_EN
  logic [CNT_W-1:0] miss_q;

  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      miss_q <= '0;
    end else if (cnt_clr_i) begin
      miss_q <= '0;
    end else if (edge_q && (state_q != StIdle) && (miss_q != '1)) begin
      miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign missed_count_o = miss_q;
`else
  assign missed_count_o = '0;
`endif

  assign pnr_clr_o    = clr_q;
  assign pnr_gate_o   = gate_q;
  assign busy_o       = (state_q != StIdle);
  assign armed_o      = armed;
  assign trig_count_o = trig_q;

endmodule

// File: tb/tb_pnr_trigger_sequencer.sv
// Directed bench for pnr_trigger_sequencer (CNT_W=4 build so saturation is reachable).
module tb_pnr_trigger_sequencer;

  localparam int unsigned DLY_W = 16;
  localparam int unsigned CNT_W = 4;

  logic             ADC_CLK = 1'b0;
  logic             rst_i = 1'b1;
  logic             ext_trig_i = 1'b0;
  logic             en_i = 1'b0;
  logic             single_i = 1'b0;
  logic             arm_i = 1'b0;
  logic [DLY_W-1:0] delay_cycles_i = '0;
  logic [DLY_W-1:0] window_cycles_i = '0;
  logic [DLY_W-1:0] holdoff_cycles_i = '0;
  logic             cnt_clr_i = 1'b0;
  logic             pnr_clr_o;
  logic             pnr_gate_o;
  logic             busy_o;
  logic             armed_o;
  logic [CNT_W-1:0] trig_count_o;
  logic [CNT_W-1:0] missed_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state, sampled on the falling edge
  int cyc = 0;
  int clr_n = 0, clr_at = 0, gate_n = 0, rise_at = 0, glen = 0, busy_run = 0, overlap = 0;
  logic gate_prev = 1'b0, busy_prev = 1'b0;

  pnr_trigger_sequencer #(
    .DLY_W(DLY_W),
    .CNT_W(CNT_W)
  ) u_dut (
    .ADC_CLK         (ADC_CLK),
    .rst_i           (rst_i),
    .ext_trig_i      (ext_trig_i),
    .en_i            (en_i),
    .single_i        (single_i),
    .arm_i           (arm_i),
    .delay_cycles_i  (delay_cycles_i),
    .window_cycles_i (window_cycles_i),
    .holdoff_cycles_i(holdoff_cycles_i),
    .cnt_clr_i       (cnt_clr_i),
    .pnr_clr_o       (pnr_clr_o),
    .pnr_gate_o      (pnr_gate_o),
    .busy_o          (busy_o),
    .armed_o         (armed_o),
    .trig_count_o    (trig_count_o),
    .missed_count_o  (missed_count_o)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  always @(posedge ADC_CLK) cyc <= cyc + 1;

  always @(negedge ADC_CLK) begin
    if (pnr_clr_o) begin
      clr_n  <= clr_n + 1;
      clr_at <= cyc;
    end
    if (pnr_gate_o && !gate_prev) begin
      gate_n  <= gate_n + 1;
      rise_at <= cyc;
      glen    <= 1;
    end else if (pnr_gate_o) begin
      glen <= glen + 1;
    end
    if (busy_o && !busy_prev) busy_run <= 1;
    else if (busy_o) busy_run <= busy_run + 1;
    if (pnr_clr_o && pnr_gate_o) overlap <= overlap + 1;
    gate_prev <= pnr_gate_o;
    busy_prev <= busy_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge ADC_CLK);
    #1;
  endtask

  task automatic fire();
    ext_trig_i = 1'b1;
    repeat (3) step();
    ext_trig_i = 1'b0;
  endtask

  task automatic wait_glen(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (pnr_gate_o && glen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_cfg(input int d, input int w, input int h);
    delay_cycles_i   = DLY_W'(d);
    window_cycles_i  = DLY_W'(w);
    holdoff_cycles_i = DLY_W'(h);
  endtask

  int t0, c0, g0;
  bit ok;
  logic [31:0] exp_miss;

  initial begin
`ifdef PNR_SEQ_MISSED_CNT_EN
    exp_miss = 1;
`else
    exp_miss = 0;
`endif
    repeat (3) step();
    rst_i = 1'b0;
    step();
    check_eq("rst_clr", 32'(pnr_clr_o), 0);
    check_eq("rst_gate", 32'(pnr_gate_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_armed", 32'(armed_o), 0);
    check_eq("rst_trig", 32'(trig_count_o), 0);
    check_eq("rst_missed", 32'(missed_count_o), 0);

    // 1: continuous, one edge
    en_i = 1'b1;
    single_i = 1'b0;
    set_cfg(4, 10, 20);
    step();
    t0 = cyc;
    c0 = clr_n;
    fire();
    repeat (50) step();
    check_eq("t1_clr_latency", 32'(clr_at - t0), 4);
    check_eq("t1_clr_pulses", 32'(clr_n - c0), 1);
    check_eq("t1_gate_delay", 32'(rise_at - clr_at), 4);
    check_eq("t1_gate_len", 32'(glen), 10);
    check_eq("t1_busy_len", 32'(busy_run), 34);
    check_eq("t1_trig", 32'(trig_count_o), 1);
    check_eq("t1_idle", 32'(busy_o), 0);

    // 2: counter clear, then second edge 8 cycles after the first
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    check_eq("t2_cleared", 32'(trig_count_o), 0);
    c0 = clr_n;
    fire();
    repeat (5) step();
    fire();
    repeat (60) step();
    check_eq("t2_clr_pulses", 32'(clr_n - c0), 1);
    check_eq("t2_trig", 32'(trig_count_o), 1);
    check_eq("t2_missed", 32'(missed_count_o), exp_miss);

    // 3: single-shot
    single_i = 1'b1;
    step();
    check_eq("t3_not_armed", 32'(armed_o), 0);
    c0 = clr_n;
    fire();
    repeat (40) step();
    check_eq("t3_unarmed_ignored", 32'(clr_n - c0), 0);
    check_eq("t3_unarmed_trig", 32'(trig_count_o), 1);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    check_eq("t3_armed", 32'(armed_o), 1);
    fire();
    repeat (97) step();
    fire();
    repeat (60) step();
    check_eq("t3_one_seq", 32'(clr_n - c0), 1);
    check_eq("t3_trig", 32'(trig_count_o), 2);
    check_eq("t3_disarmed", 32'(armed_o), 0);
    check_eq("t3_missed", 32'(missed_count_o), exp_miss);

    // 4: zero delay/window/holdoff
    single_i = 1'b0;
    set_cfg(0, 0, 0);
    c0 = clr_n;
    g0 = gate_n;
    fire();
    repeat (20) step();
    check_eq("t4_clr", 32'(clr_n - c0), 1);
    check_eq("t4_no_gate", 32'(gate_n - g0), 0);
    check_eq("t4_busy_len", 32'(busy_run), 2);
    check_eq("t4_idle", 32'(busy_o), 0);
    fire();
    repeat (20) step();
    check_eq("t4_next_accepted", 32'(clr_n - c0), 2);

    // 5: enable drop mid-window, then async reset mid-window
    set_cfg(4, 10, 20);
    fire();
    wait_glen(3, ok);
    check_eq("t5_reach_gate3", 32'(ok), 1);
    en_i = 1'b0;
    step();
    check_eq("t5_gate_off", 32'(pnr_gate_o), 0);
    check_eq("t5_busy_off", 32'(busy_o), 0);
    check_eq("t5_gate_len", 32'(glen), 3);
    check_eq("t5_armed_off", 32'(armed_o), 0);
    en_i = 1'b1;
    fire();
    wait_glen(2, ok);
    check_eq("t5_reach_gate2", 32'(ok), 1);
    rst_i = 1'b1;
    #1;
    check_eq("t5_rst_gate", 32'(pnr_gate_o), 0);
    check_eq("t5_rst_busy", 32'(busy_o), 0);
    check_eq("t5_rst_trig", 32'(trig_count_o), 0);
    step();
    rst_i = 1'b0;
    step();

    // 6: saturation and clear-wins-over-accept
    set_cfg(0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      fire();
      repeat (5) step();
    end
    check_eq("t6_count15", 32'(trig_count_o), 15);
    for (int i = 0; i < 2; i++) begin
      fire();
      repeat (5) step();
    end
    check_eq("t6_saturated", 32'(trig_count_o), 15);
    ext_trig_i = 1'b1;
    repeat (3) step();
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    ext_trig_i = 1'b0;
    check_eq("t6_accept_seen", 32'(pnr_clr_o), 1);
    check_eq("t6_clr_wins", 32'(trig_count_o), 0);
    repeat (5) step();
    check_eq("overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
